// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the memory stage: op codes, LSU FSM states and
// small op-classification helpers.
package cpu_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Codes 9..15 fall to default and behave as NONE.
  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LW, MEM_SW:          return a != 2'b00;
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension of a returned data word.
module mem_load_ext
  import cpu_mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    w_half = '0;
    o_data = i_word;
    unique case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    case (i_op)
      MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {24'h0, w_byte};
      MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: drives the data-memory handshake, stalls upstream while
// an access is outstanding and presents a bubble to MEM/WB during stalls.
module mem_stage_lsu
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_have_inst,
  input  logic [31:0]       ex_pc,
  input  logic [4:0]        ex_wr,
  input  logic              ex_rf_we,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_aluc,
  input  logic [31:0]       ex_rf_wdata,
  input  logic [31:0]       ex_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_have_inst,
  output logic              mem_rf_we,
  output logic [4:0]        mem_wr,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_rf_wdata
);

  lsu_state_e        r_state;
  logic [31:0]       r_ld_buf;
  logic [1:0]        r_ld_shift;

  logic [ADDR_W-1:0] w_addr;
  logic              w_load;
  logic              w_store;
  logic              w_misalign;
  logic              w_access;
  logic              w_bus;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;

  assign w_addr     = ex_aluc[ADDR_W-1:0];
  assign w_load     = ex_have_inst & is_load(ex_mem_op);
  assign w_store    = ex_have_inst & is_store(ex_mem_op);
  assign w_misalign = (w_load | w_store) & is_misaligned(ex_mem_op, w_addr[1:0]);
  assign w_access   = (w_load | w_store) & ~w_misalign;
  assign w_bus      = ((r_state == ST_IDLE) & w_access) | (r_state == ST_REQ);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data;
    case (ex_mem_op)
      MEM_SB: begin
        w_be    = 4'(4'b0001 << w_addr[1:0]);
        w_wdata = {4{ex_store_data[7:0]}};
      end
      MEM_SH: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_ext u_load_ext (
    .i_op   (ex_mem_op),
    .i_addr (r_ld_shift),
    .i_word (r_ld_buf),
    .o_data (w_ext)
  );

  // Outputs are combinational so stores and pass-through ops finish in-cycle;
  // asserting reset forces everything low regardless of the ex_* inputs.
  always_comb begin
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_be       = '0;
    dmem_wdata    = '0;
    mem_stall     = 1'b0;
    mem_misalign  = 1'b0;
    mem_have_inst = 1'b0;
    mem_rf_we     = 1'b0;
    mem_wr        = '0;
    mem_pc        = '0;
    mem_rf_wdata  = '0;
    if (rst_n_i) begin
      if (w_bus) begin
        dmem_req   = 1'b1;
        dmem_we    = w_store;
        dmem_addr  = {w_addr[ADDR_W-1:2], 2'b00};
        dmem_be    = w_be;
        dmem_wdata = w_store ? w_wdata : '0;
        mem_stall  = ~(w_store & dmem_ready);
      end else begin
        mem_stall  = (r_state == ST_WAIT);
      end
      mem_misalign = (r_state == ST_IDLE) & w_misalign;
      if (!mem_stall) begin
        mem_wr       = ex_wr;
        mem_pc       = ex_pc;
        mem_rf_wdata = ex_rf_wdata;
        if (r_state == ST_DONE) begin
          mem_have_inst = 1'b1;
          mem_rf_we     = ex_rf_we;
          mem_rf_wdata  = w_ext;
        end else if (w_bus || w_misalign) begin
          mem_have_inst = 1'b1;
        end else begin
          mem_have_inst = ex_have_inst;
          mem_rf_we     = ex_have_inst & ex_rf_we;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_ld_buf   <= '0;
      r_ld_shift <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_access && !(w_store && dmem_ready)) begin
            r_ld_shift <= w_addr[1:0];
            r_state    <= dmem_ready ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_ready) r_state <= w_store ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            r_ld_buf <= dmem_rdata;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table, directed load/reset sequences and
// randomized transactions against a transaction-level reference model.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ex_have_inst;
  logic [31:0] ex_pc;
  logic [4:0]  ex_wr;
  logic        ex_rf_we;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_aluc;
  logic [31:0] ex_rf_wdata;
  logic [31:0] ex_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_have_inst;
  logic        mem_rf_we;
  logic [4:0]  mem_wr;
  logic [31:0] mem_pc;
  logic [31:0] mem_rf_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ex_have_inst(ex_have_inst), .ex_pc(ex_pc), .ex_wr(ex_wr), .ex_rf_we(ex_rf_we),
    .ex_mem_op(ex_mem_op), .ex_aluc(ex_aluc), .ex_rf_wdata(ex_rf_wdata),
    .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_have_inst(mem_have_inst),
    .mem_rf_we(mem_rf_we), .mem_wr(mem_wr), .mem_pc(mem_pc), .mem_rf_wdata(mem_rf_wdata)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: pick the addressed lane by shifting, then extend by op kind.
  function automatic logic [31:0] ref_ext(input logic [3:0] op, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a);
    case (op)
      4'd1:    return 32'($signed(s[7:0]));
      4'd2:    return 32'($signed(s[15:0]));
      4'd4:    return {24'h0, s[7:0]};
      4'd5:    return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd3 || op == 4'd8) return a[1:0] != 2'b00;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [1:0] a);
    if (op == 4'd6) return 4'(1 << a);
    if (op == 4'd7) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == 4'd6) return {4{d[7:0]}};
    if (op == 4'd7) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic set_ex(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rfw, input logic rfwe);
    ex_have_inst  = 1'b1;
    ex_mem_op     = op;
    ex_aluc       = addr;
    ex_store_data = sdata;
    ex_rf_wdata   = rfw;
    ex_rf_we      = rfwe;
    ex_pc         = $urandom;
    ex_wr         = 5'($urandom);
  endtask

  // Whole transaction: ready after d_r low cycles, rvalid d_v cycles after the
  // earliest legal slot; the stage stays in MEM until the final cycle fin.
  task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rfw, input logic rfwe,
                         input int unsigned d_r, input int unsigned d_v,
                         input logic [31:0] rd);
    logic ld, st, mis, acc;
    int unsigned fin, vc;
    ld  = (op >= 4'd1 && op <= 4'd5);
    st  = (op >= 4'd6 && op <= 4'd8);
    mis = ref_misaligned(op, addr);
    acc = (ld || st) && !mis;
    vc  = d_r + 1 + d_v;
    fin = !acc ? 0 : (st ? d_r : d_r + d_v + 2);
    set_ex(op, addr, sdata, rfw, rfwe);
    for (int unsigned c = 0; c <= fin; c++) begin
      if (!acc) dmem_ready = 1'($urandom);
      else      dmem_ready = (c < d_r) ? 1'b0 : (c == d_r) ? 1'b1 : 1'($urandom);
      if (acc && ld && c == vc) dmem_rvalid = 1'b1;
      else if (c <= d_r || c == fin || !acc) dmem_rvalid = 1'($urandom);
      else dmem_rvalid = 1'b0;
      dmem_rdata = (acc && ld && c == vc) ? rd : $urandom;
      #4;
      if (c < fin) begin
        chk({nm, " stall"}, 32'(mem_stall), 32'd1);
        chk({nm, " bubble_have"}, 32'(mem_have_inst), 32'd0);
        chk({nm, " bubble_we"}, 32'(mem_rf_we), 32'd0);
        chk({nm, " bubble_wdata"}, mem_rf_wdata, 32'd0);
        chk({nm, " bubble_pc"}, mem_pc, 32'd0);
        chk({nm, " req"}, 32'(dmem_req), 32'(c <= d_r));
        if (c == d_r) begin
          chk({nm, " ld_be"}, 32'(dmem_be), 32'hF);
          chk({nm, " ld_we"}, 32'(dmem_we), 32'd0);
          chk({nm, " ld_addr"}, dmem_addr, addr & ~32'd3);
        end
      end else begin
        chk({nm, " stall"}, 32'(mem_stall), 32'd0);
        chk({nm, " misalign"}, 32'(mem_misalign), 32'(mis));
        chk({nm, " have"}, 32'(mem_have_inst), 32'd1);
        chk({nm, " rf_we"}, 32'(mem_rf_we), 32'((acc && ld) ? rfwe : (ld || st) ? 1'b0 : rfwe));
        chk({nm, " pc"}, mem_pc, ex_pc);
        chk({nm, " wr"}, 32'(mem_wr), 32'(ex_wr));
        chk({nm, " req"}, 32'(dmem_req), 32'(acc && st));
        if (!st) chk({nm, " wdata"}, mem_rf_wdata, (acc && ld) ? ref_ext(op, addr[1:0], rd) : rfw);
        if (acc && st) begin
          chk({nm, " st_we"}, 32'(dmem_we), 32'd1);
          chk({nm, " st_be"}, 32'(dmem_be), 32'(ref_be(op, addr[1:0])));
          chk({nm, " st_data"}, dmem_wdata, ref_wdata(op, sdata));
          chk({nm, " st_addr"}, dmem_addr, addr & ~32'd3);
        end
      end
      tick();
    end
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // LB/LBU at 0x102 with a zero-wait slave: two stall cycles then the result.
  task automatic lb_seq(input string nm, input logic [3:0] op, input logic [31:0] exp);
    set_ex(op, 32'h102, 32'h0, 32'h0, 1'b1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    #4;
    chk({nm, " c0_stall"}, 32'(mem_stall), 32'd1);
    chk({nm, " c0_req"}, 32'(dmem_req), 32'd1);
    tick();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0080FF00;
    #4;
    chk({nm, " c1_stall"}, 32'(mem_stall), 32'd1);
    chk({nm, " c1_req"}, 32'(dmem_req), 32'd0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    #4;
    chk({nm, " c2_stall"}, 32'(mem_stall), 32'd0);
    chk({nm, " c2_have"}, 32'(mem_have_inst), 32'd1);
    chk({nm, " c2_we"}, 32'(mem_rf_we), 32'd1);
    chk({nm, " c2_wdata"}, mem_rf_wdata, exp);
    tick();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rfw;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_dw;
    logic [31:0] e_daddr;
    logic        e_mis;
    logic        e_rfwe;
    logic        chk_wd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd0,  32'h0000_0000, 32'h0,         32'h1234, 1'b0, 4'h0, 32'h0,         32'h0,   1'b0, 1'b1, 1'b1, 32'h1234};
    vecs[1] = '{4'd6,  32'h0000_0103, 32'h0000_00AB, 32'h0,    1'b1, 4'h8, 32'hABABABAB, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{4'd7,  32'h0000_0102, 32'h1234_CAFE, 32'h0,    1'b1, 4'hC, 32'hCAFECAFE, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{4'd8,  32'h0000_0204, 32'hDEAD_BEEF, 32'h0,    1'b1, 4'hF, 32'hDEADBEEF, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{4'd6,  32'h0000_0100, 32'h0000_0017, 32'h0,    1'b1, 4'h1, 32'h17171717, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{4'd2,  32'h0000_0101, 32'h0,         32'h77,   1'b0, 4'h0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1, 32'h77};
    vecs[6] = '{4'd8,  32'h0000_0102, 32'h5555_5555, 32'h88,   1'b0, 4'h0, 32'h0,         32'h0,   1'b1, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{4'd12, 32'h0000_0040, 32'h0,         32'h9999, 1'b0, 4'h0, 32'h0,         32'h0,   1'b0, 1'b1, 1'b1, 32'h9999};

    rst_n_i = 1'b0;
    set_ex(4'd3, 32'h100, 32'h0, 32'h0, 1'b1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #4;
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst stall", 32'(mem_stall), 32'd0);
    chk("rst have", 32'(mem_have_inst), 32'd0);
    chk("rst pc", mem_pc, 32'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    ex_have_inst = 1'b0;
    tick();

    for (int unsigned i = 0; i < 8; i++) begin
      set_ex(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rfw, 1'b1);
      dmem_ready = 1'b1;
      #4;
      chk($sformatf("vec%0d stall", i), 32'(mem_stall), 32'd0);
      chk($sformatf("vec%0d req", i), 32'(dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d misalign", i), 32'(mem_misalign), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d have", i), 32'(mem_have_inst), 32'd1);
      chk($sformatf("vec%0d rf_we", i), 32'(mem_rf_we), 32'(vecs[i].e_rfwe));
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d be", i), 32'(dmem_be), 32'(vecs[i].e_be));
        chk($sformatf("vec%0d dwdata", i), dmem_wdata, vecs[i].e_dw);
        chk($sformatf("vec%0d daddr", i), dmem_addr, vecs[i].e_daddr);
      end
      if (vecs[i].chk_wd) chk($sformatf("vec%0d wdata", i), mem_rf_wdata, vecs[i].e_wd);
      tick();
    end
    dmem_ready = 1'b0;

    lb_seq("lb", 4'd1, 32'hFFFF_FF80);
    lb_seq("lbu", 4'd4, 32'h0000_0080);
    run_txn("lw_wait", 4'd3, 32'h300, 32'h0, 32'h0, 1'b1, 3, 1, 32'hC0FF_EE11);

    set_ex(4'd1, 32'h102, 32'h0, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1 rst_n_i = 1'b0;
    #2;
    chk("rstwait stall", 32'(mem_stall), 32'd0);
    chk("rstwait req", 32'(dmem_req), 32'd0);
    chk("rstwait have", 32'(mem_have_inst), 32'd0);
    tick();
    rst_n_i = 1'b1;
    ex_have_inst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    #4;
    chk("postrst stall", 32'(mem_stall), 32'd0);
    chk("postrst have", 32'(mem_have_inst), 32'd0);
    chk("postrst req", 32'(dmem_req), 32'd0);
    chk("postrst rf_we", 32'(mem_rf_we), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    set_ex(4'd0, 32'h0, 32'h0, 32'h55, 1'b1);
    #4;
    chk("postrst alu stall", 32'(mem_stall), 32'd0);
    chk("postrst alu wdata", mem_rf_wdata, 32'h55);
    tick();

    for (int unsigned n = 0; n < 300; n++) begin
      run_txn($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), $urandom, $urandom,
              $urandom, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs loads and stores on the data-memory bus with a ready/rvalid handshake, and sizes and extends load data.
- Stalls upstream while an access is outstanding.
- Produces mem_rf_we, mem_have_inst, mem_wr, mem_pc and mem_rf_wdata for the MEM/WB register. That register captures every cycle and has no enable, so this block emits a bubble whenever it stalls.

Parameters:
- ADDR_W, 32, data-memory byte-address width; the upper bits of the ALU result beyond ADDR_W are dropped.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- ex_have_inst  in  1  EX/MEM slot holds a valid instruction
- ex_pc  in  32  instruction PC
- ex_wr  in  5  destination register
- ex_rf_we  in  1  register write enable from decode
- ex_mem_op  in  4  memory op (package encoding)
- ex_aluc  in  32  ALU result: the address for memory ops, the write data otherwise
- ex_rf_wdata  in  32  pre-selected write-back data for non-load ops
- ex_store_data  in  32  rs2 value for stores
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  slave accepts the request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- mem_stall  out  1  hold IF..EX/MEM this cycle
- mem_misalign  out  1  misaligned-access pulse
- mem_have_inst, mem_rf_we, mem_wr[5], mem_pc[32], mem_rf_wdata[32]  out  to MEM/WB

Behaviour:
- Reset is rst_n_i, asynchronous, active-low; clock is clk_i. Reset forces state IDLE, clears ld_buf to 0 and ld_shift to 0, and drives all outputs low/0.
- Upstream holds ex_* stable while mem_stall=1. The block relies on this and does not latch the request fields.
- Non-memory op (NONE), or ex_have_inst=0: combinational pass-through in the same cycle.
  - mem_rf_wdata=ex_rf_wdata; no stall; dmem_req=0.
- Alignment: LW/SW require addr[1:0]=0; LH/LHU/SH require addr[0]=0.
- Misaligned access (with ex_have_inst=1):
  - mem_misalign=1 for one cycle; no bus request; no stall.
  - mem_have_inst=1, mem_rf_we=0.
- Stores:
  - SB: be=1<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111.
- Loads: be=1111; the lane is selected by the captured addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, aligned memory op:
  - dmem_req=1 combinationally.
  - Store with ready=1: completes; stall=0; output valid this cycle with mem_rf_we=0.
  - Load with ready=1: go to WAIT; stall=1.
  - ready=0: go to REQ; stall=1.
- REQ: dmem_req=1, address and data held.
  - On ready, a store returns to IDLE with stall=0 and output valid.
  - On ready, a load goes to WAIT with stall=1.
- WAIT: dmem_req=0, stall=1. On rvalid: ld_buf<=rdata, go to DONE.
- DONE: stall=0. mem_rf_wdata=extend(ld_buf), mem_rf_we=ex_rf_we, mem_have_inst=1. Go to IDLE.
- Load latency: acceptance cycle + ≥1 rvalid wait + 1 DONE cycle, i.e. at least 3 cycles in MEM for a zero-wait slave.
- While mem_stall=1: mem_have_inst=0 and mem_rf_we=0 (bubble); mem_wr, mem_pc and mem_rf_wdata are 0.
- dmem_rvalid outside WAIT is ignored. The slave guarantees rvalid arrives ≥1 cycle after ready.
- dmem_ready is ignored when dmem_req=0.
- Reset asserted mid-access returns the block to IDLE immediately; the outstanding rvalid is discarded because the block is not in WAIT.

Decomposition:
- Package cpu_mem_pkg holds:
  - MEM_OP encoding: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8, 9..15 treated as NONE.
  - State encoding.
  - Helpers is_load and is_store.
- Sub-module mem_load_ext: a combinational lane-select and sign/zero-extend unit taking (op, addr[1:0], word).

Test Plan:
- ALU op, ex_rf_wdata=0x1234, have_inst=1 -> same cycle mem_rf_wdata=0x1234, mem_stall=0, dmem_req=0.
- SB addr=0x103, data=0xAB, ready=1 -> dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100, no stall, mem_rf_we=0.
- LB addr=0x102, ready=1, rvalid next cycle with rdata=0x0080FF00 -> 2 stall cycles, then mem_rf_wdata=0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
- LW with ready held low 3 cycles, then rvalid 2 cycles after acceptance -> mem_stall high 6 cycles, mem_have_inst=0 throughout, then one cycle valid with the word.
- LH addr=0x101 -> mem_misalign=1, dmem_req=0, mem_rf_we=0, mem_have_inst=1, no stall.
- Reset pulsed while in WAIT, then rvalid arrives -> state IDLE, rvalid ignored, all outputs 0.
